spi_wishbone_arbiter: RTL and testbench



---
 rtl/spi_wishbone_arbiter.sv | 162 ++++++++++++++++
 tb/tb_spi_wishbone_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wishbone_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one SPI master Wishbone slave port among NUM_REQ byte requesters.
// Optional macro SPI_ARB_CSHOLD_LOCK_EN keeps CSHOLD (ADR bit 7) multi-byte frames atomic.
module spi_wishbone_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic [NUM_REQ-1:0]   reqStb,
  input  logic [NUM_REQ*8-1:0] reqAdr,
  input  logic [NUM_REQ*8-1:0] reqDat,
  output logic [NUM_REQ-1:0]   reqAck,
  output logic [7:0]           rxData,
  output logic                 busy,
  output logic                 STB_O,
  output logic                 WE_O,
  output logic [7:0]           ADR_O,
  output logic [7:0]           DAT_O,
  input  logic                 ACK_I,
  input  logic                 RTY_I,
  input  logic [7:0]           DAT_I
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE, RESPOND} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   grant, grant_d, last_grant, last_grant_d;
  logic [IDX_W-1:0]   rr_idx, cand, win_idx;
  logic               rr_found, win_valid;
  logic [7:0]         adr_arr [NUM_REQ];
  logic [7:0]         dat_arr [NUM_REQ];
  logic [NUM_REQ-1:0] req_ack_d;
  logic [7:0]         rx_data_d, adr_d, dat_d;
  logic               stb_d, we_d, busy_d;
`ifdef SPI_ARB_CSHOLD_LOCK_EN
  logic               locked, locked_d;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign adr_arr[g] = reqAdr[8*g +: 8];
    assign dat_arr[g] = reqDat[8*g +: 8];
  end

  // Descending offsets so the nearest requester after last_grant is the final (winning) assignment.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_grant;
    cand     = '0;
    for (int unsigned off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((32'(last_grant) + off) % NUM_REQ);
      if (reqStb[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  always_comb begin
`ifdef SPI_ARB_CSHOLD_LOCK_EN
    if (locked) begin
      win_valid = reqStb[last_grant];
      win_idx   = last_grant;
    end else begin
      win_valid = rr_found;
      win_idx   = rr_idx;
    end
`else
    win_valid = rr_found;
    win_idx   = rr_idx;
`endif
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    adr_d        = ADR_O;
    dat_d        = DAT_O;
    stb_d        = STB_O;
    we_d         = WE_O;
    rx_data_d    = rxData;
    req_ack_d    = '0;
`ifdef SPI_ARB_CSHOLD_LOCK_EN
    locked_d     = locked;
`endif
    case (state)
      IDLE: begin
        if (win_valid) begin
          grant_d = win_idx;
          adr_d   = adr_arr[win_idx];
          dat_d   = dat_arr[win_idx];
          stb_d   = 1'b1;
          we_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ACK_I) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (RTY_I) state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!RTY_I) begin
          rx_data_d        = DAT_I;
          req_ack_d[grant] = 1'b1;
          state_d          = RESPOND;
        end
      end
      RESPOND: begin
        last_grant_d = grant;
`ifdef SPI_ARB_CSHOLD_LOCK_EN
        locked_d     = ADR_O[7];
`endif
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      grant      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      ADR_O      <= 8'h00;
      DAT_O      <= 8'h00;
      STB_O      <= 1'b0;
      WE_O       <= 1'b0;
      rxData     <= 8'h00;
      reqAck     <= '0;
      busy       <= 1'b0;
`ifdef SPI_ARB_CSHOLD_LOCK_EN
      locked     <= 1'b0;
`endif
    end else begin
      grant      <= grant_d;
      last_grant <= last_grant_d;
      ADR_O      <= adr_d;
      DAT_O      <= dat_d;
      STB_O      <= stb_d;
      WE_O       <= we_d;
      rxData     <= rx_data_d;
      reqAck     <= req_ack_d;
      busy       <= busy_d;
`ifdef SPI_ARB_CSHOLD_LOCK_EN
      locked     <= locked_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_wishbone_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for spi_wishbone_arbiter: requester drivers, SPI-master slave model, scoreboard.
module tb_spi_wishbone_arbiter;

  localparam int unsigned NUM_REQ = 4;

  logic                 CLK_I = 1'b0;
  logic                 RST_I;
  logic [NUM_REQ-1:0]   reqStb;
  logic [NUM_REQ*8-1:0] reqAdr;
  logic [NUM_REQ*8-1:0] reqDat;
  logic [NUM_REQ-1:0]   reqAck;
  logic [7:0]           rxData;
  logic                 busy;
  logic                 STB_O;
  logic                 WE_O;
  logic [7:0]           ADR_O;
  logic [7:0]           DAT_O;
  logic                 ACK_I;
  logic                 RTY_I;
  logic [7:0]           DAT_I;

  spi_wishbone_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .reqStb(reqStb), .reqAdr(reqAdr), .reqDat(reqDat),
    .reqAck(reqAck), .rxData(rxData), .busy(busy),
    .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .ACK_I(ACK_I), .RTY_I(RTY_I), .DAT_I(DAT_I)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct { int idx; logic [7:0] adr; logic [7:0] dat; logic [7:0] rx; } exp_t;
  typedef struct { int idx; logic [7:0] adr; logic [7:0] dat; int ack_delay; int busy_len; logic [7:0] rx; } vec_t;

  exp_t sb[$];
  vec_t tbl [6];
  int errors, checks;

  // slave model knobs
  int ack_delay, busy_len, rty_gap;
  int sst, mcnt;
  logic [7:0] mreply;

  // requester drivers
  logic [15:0] pbuf [NUM_REQ][32];
  int pwr [NUM_REQ];
  int prd [NUM_REQ];
  logic [NUM_REQ-1:0] drop_req;

  // monitor state
  int cyc, last_ack_cyc;
  logic stb_prev, in_xfer;
  bit chk_b2b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK_I);
      #1;
    end
  endtask

  function automatic bit pend_left();
    bit r = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (prd[i] != pwr[i]) r = 1'b1;
    return r;
  endfunction

  task automatic enq(input int i, input logic [7:0] adr, input logic [7:0] dat);
    pbuf[i][pwr[i]] = {adr, dat};
    pwr[i]++;
  endtask

  task automatic expect_xfer(input int i, input logic [7:0] adr, input logic [7:0] dat, input logic [7:0] rx);
    exp_t e;
    e.idx = i; e.adr = adr; e.dat = dat; e.rx = rx;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || reqStb != '0 || pend_left()) && n < budget) begin
      step(1);
      n++;
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_busy", busy, 0);
    sb.delete();
  endtask

  task automatic wait_stb(input logic level, input int budget);
    int n;
    n = 0;
    while (STB_O !== level && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_stb", STB_O, level);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_stb"}, STB_O, 0);
    chk({tag, "_we"}, WE_O, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ack"}, reqAck, 0);
    chk({tag, "_adr"}, ADR_O, 8'h00);
    chk({tag, "_dat"}, DAT_O, 8'h00);
    chk({tag, "_rx"}, rxData, 8'h00);
  endtask

  task automatic do_reset();
    RST_I = 1'b1;
    step(2);
    RST_I = 1'b0;
    sb.delete();
  endtask

  // SPI master slave model: ACK after ack_delay, optional gap, RTY busy window, then reply byte.
  initial begin
    ACK_I = 1'b0; RTY_I = 1'b0; DAT_I = 8'h00; sst = 0; mcnt = 0; mreply = 8'h00;
    forever begin
      @(posedge CLK_I);
      #1;
      if (sst != 0 && !busy) begin
        ACK_I = 1'b0; RTY_I = 1'b0; sst = 0;
      end else begin
        case (sst)
          0: if (STB_O) begin
               mreply = DAT_O ^ 8'h99;
               mcnt = ack_delay;
               if (mcnt == 0) begin ACK_I = 1'b1; sst = 2; end
               else sst = 1;
             end
          1: begin
               mcnt--;
               if (mcnt == 0) begin ACK_I = 1'b1; sst = 2; end
             end
          2: begin
               ACK_I = 1'b0;
               if (rty_gap == 0) begin RTY_I = 1'b1; mcnt = busy_len; sst = 3; end
               else begin mcnt = rty_gap; sst = 4; end
             end
          3: begin
               mcnt--;
               if (mcnt <= 0) begin RTY_I = 1'b0; DAT_I = mreply; sst = 0; end
             end
          4: begin
               mcnt--;
               if (mcnt <= 0) begin RTY_I = 1'b1; mcnt = busy_len; sst = 3; end
             end
          default: sst = 0;
        endcase
      end
    end
  end

  // Requesters: raise queued byte requests, drop strobe on own ack or when told to abort.
  initial begin
    reqStb = '0; reqAdr = '0; reqDat = '0;
    for (int i = 0; i < NUM_REQ; i++) prd[i] = 0;
    forever begin
      @(posedge CLK_I);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (reqAck[i] || drop_req[i]) reqStb[i] = 1'b0;
        else if (!reqStb[i] && prd[i] != pwr[i]) begin
          reqAdr[8*i +: 8] = pbuf[i][prd[i]][15:8];
          reqDat[8*i +: 8] = pbuf[i][prd[i]][7:0];
          reqStb[i] = 1'b1;
          prd[i]++;
        end
      end
    end
  end

  // Scoreboard monitor on the falling edge.
  initial begin
    cyc = 0; last_ack_cyc = -1; stb_prev = 1'b0; in_xfer = 1'b0;
    forever begin
      @(negedge CLK_I);
      cyc++;
      if (RST_I) begin
        in_xfer = 1'b0; last_ack_cyc = -1; stb_prev = 1'b0;
      end else begin
        if (STB_O && !stb_prev) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_unexpected: ADR_O=%h DAT_O=%h with no transfer expected (t=%0t)", ADR_O, DAT_O, $time);
          end else begin
            chk("grant_adr", ADR_O, sb[0].adr);
            chk("grant_dat", DAT_O, sb[0].dat);
            chk("grant_we", WE_O, 1);
            chk("grant_busy", busy, 1);
            if (chk_b2b && last_ack_cyc >= 0) chk("b2b_gap", cyc - last_ack_cyc, 2);
            in_xfer = 1'b1;
          end
        end else if (in_xfer && sb.size() != 0) begin
          chk("hold_adr", ADR_O, sb[0].adr);
          chk("hold_dat", DAT_O, sb[0].dat);
        end
        if (reqAck != '0) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL ack_unexpected: reqAck=%b with no transfer expected (t=%0t)", reqAck, $time);
          end else begin
            chk("ack_onehot", reqAck, 32'(1) << sb[0].idx);
            chk("ack_rx", rxData, sb[0].rx);
            sb.delete(0);
          end
          in_xfer = 1'b0;
          last_ack_cyc = cyc;
        end
        stb_prev = STB_O;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    RST_I = 1'b1;
    errors = 0; checks = 0; chk_b2b = 1'b0; drop_req = '0;
    ack_delay = 0; busy_len = 2; rty_gap = 0;
    for (int i = 0; i < NUM_REQ; i++) pwr[i] = 0;

    tbl[0] = '{0, 8'h01, 8'hA5, 0, 2, 8'h3C};
    tbl[1] = '{1, 8'h05, 8'h00, 1, 1, 8'h99};
    tbl[2] = '{2, 8'h7F, 8'hFF, 3, 5, 8'h66};
    tbl[3] = '{3, 8'h4C, 8'h5A, 0, 3, 8'hC3};
    tbl[4] = '{0, 8'h10, 8'h99, 2, 1, 8'h00};
    tbl[5] = '{3, 8'h03, 8'h3C, 0, 2, 8'hA5};

    step(3);
    RST_I = 1'b0;
    check_reset("por");

    for (int k = 0; k < 6; k++) begin
      ack_delay = tbl[k].ack_delay;
      busy_len  = tbl[k].busy_len;
      expect_xfer(tbl[k].idx, tbl[k].adr, tbl[k].dat, tbl[k].rx);
      enq(tbl[k].idx, tbl[k].adr, tbl[k].dat);
      wait_done(100);
    end

    // ACK_I withheld for 10 cycles: strobe must stay up the whole time
    ack_delay = 10; busy_len = 2;
    expect_xfer(2, 8'h22, 8'h44, 8'hDD);
    enq(2, 8'h22, 8'h44);
    wait_stb(1'b1, 20);
    cnt = 0;
    while (STB_O && cnt < 40) begin
      step(1);
      cnt++;
    end
    chk("stb_hold_cycles", cnt, 11);
    wait_done(100);
    ack_delay = 0;

    // All four at once from reset: strict 0,1,2,3 order, back-to-back grants
    do_reset();
    chk_b2b = 1'b1;
    ack_delay = 1; busy_len = 2;
    for (int i = 0; i < NUM_REQ; i++) begin
      expect_xfer(i, 8'h10 + 8'(i), 8'hC0 + 8'(i), (8'hC0 + 8'(i)) ^ 8'h99);
      enq(i, 8'h10 + 8'(i), 8'hC0 + 8'(i));
    end
    wait_done(300);
    chk_b2b = 1'b0;
    expect_xfer(0, 8'h20, 8'h0F, 8'h96);
    enq(0, 8'h20, 8'h0F);
    wait_done(100);
    ack_delay = 0;

    // Requester 2 abandons its strobe in WAIT_BUSY; transfer still completes once
    rty_gap = 3; busy_len = 2;
    expect_xfer(2, 8'h09, 8'h6E, 8'hF7);
    enq(2, 8'h09, 8'h6E);
    wait_stb(1'b1, 20);
    wait_stb(1'b0, 20);
    drop_req[2] = 1'b1;
    wait_done(100);
    step(8);
    chk("no_regrant_busy", busy, 0);
    drop_req[2] = 1'b0;
    rty_gap = 0;

    // Reset while waiting for the SPI master to go idle
    busy_len = 8;
    expect_xfer(0, 8'h0A, 8'h5F, 8'hC6);
    enq(0, 8'h0A, 8'h5F);
    wait_stb(1'b1, 20);
    wait_stb(1'b0, 20);
    step(2);
    chk("pre_reset_busy", busy, 1);
    sb.delete();
    RST_I = 1'b1;
    drop_req[0] = 1'b1;
    step(1);
    check_reset("mid_xfer");
    RST_I = 1'b0;
    step(1);
    drop_req[0] = 1'b0;
    busy_len = 2;
    expect_xfer(1, 8'h01, 8'h77, 8'hEE);
    enq(1, 8'h01, 8'h77);
    wait_done(100);

    // After reset requester 0 beats requester 1 when both ask
    do_reset();
    expect_xfer(0, 8'h31, 8'h12, 8'h8B);
    expect_xfer(1, 8'h32, 8'h34, 8'hAD);
    enq(0, 8'h31, 8'h12);
    enq(1, 8'h32, 8'h34);
    wait_done(200);

    // CSHOLD frame from requester 1 with requester 3 contending
    do_reset();
    busy_len = 1;
    enq(1, 8'h82, 8'h11);
    enq(1, 8'h02, 8'h22);
    enq(3, 8'h03, 8'h33);
    expect_xfer(1, 8'h82, 8'h11, 8'h88);
`ifdef SPI_ARB_CSHOLD_LOCK_EN
    expect_xfer(1, 8'h02, 8'h22, 8'hBB);
    expect_xfer(3, 8'h03, 8'h33, 8'hAA);
`else
    expect_xfer(3, 8'h03, 8'h33, 8'hAA);
    expect_xfer(1, 8'h02, 8'h22, 8'hBB);
`endif
    wait_done(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
